// File: rtl/shift_issue_stage.sv
// Issue stage for the 16-bit barrel shifter: operand FIFO, opcode decode and a registered result slot.
// Optional macro SHIFT_ISSUE_ZFLAG_EN adds the registered zero flag on out_z; otherwise out_z is tied low.
module shift_issue_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  input  logic [15:0] in_rs_val,
  output logic [15:0] sh_in,
  output logic [3:0]  sh_val,
  output logic [1:0]  sh_mode,
  input  logic [15:0] sh_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [3:0]  out_rd,
  output logic        out_z,
  output logic        illegal
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [15:0]   r_val  [DEPTH];
  logic [3:0]    r_imm  [DEPTH];
  logic [1:0]    r_mode [DEPTH];
  logic [3:0]    r_rd   [DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;

  logic        r_outValid;
  logic [15:0] r_outData;
  logic [3:0]  r_outRd;
  logic        r_illegal;

  logic       w_legal;
  logic [1:0] w_mode;
  logic       w_accept;
  logic       w_push;
  logic       w_pop;
  logic       w_empty;
  logic       w_unusedRs;

  // rs is resolved upstream; only its value arrives here
  assign w_unusedRs = ^in_instr[7:4];

  always_comb begin
    w_legal = 1'b1;
    w_mode  = 2'b00;
    case (in_instr[15:12])
      4'b0100: w_mode = 2'b00;
      4'b0101: w_mode = 2'b01;
      4'b0110: w_mode = 2'b10;
      default: begin
        w_legal = 1'b0;
        w_mode  = 2'b11;
      end
    endcase
  end

  assign w_empty  = (r_count == '0);
  assign in_ready = (r_count != FULL);
  assign w_accept = in_valid & in_ready;
  assign w_push   = w_accept & w_legal;
  assign w_pop    = !w_empty & (!r_outValid | out_ready);

  // Empty FIFO presents mode 2'b11 so the shifter simply passes its operand through
  assign sh_in   = w_empty ? 16'h0000 : r_val[r_rdPtr];
  assign sh_val  = w_empty ? 4'h0    : r_imm[r_rdPtr];
  assign sh_mode = w_empty ? 2'b11   : r_mode[r_rdPtr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_val[i]  <= '0;
        r_imm[i]  <= '0;
        r_mode[i] <= '0;
        r_rd[i]   <= '0;
      end
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_val[r_wrPtr]  <= in_rs_val;
        r_imm[r_wrPtr]  <= in_instr[3:0];
        r_mode[r_wrPtr] <= w_mode;
        r_rd[r_wrPtr]   <= in_instr[11:8];
        r_wrPtr         <= r_wrPtr + PW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Result slot only clears valid when drained without a replacement arriving
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outRd    <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_illegal <= w_accept & !w_legal;
      if (w_pop) begin
        r_outValid <= 1'b1;
        r_outData  <= sh_out;
        r_outRd    <= r_rd[r_rdPtr];
      end else if (r_outValid && out_ready) begin
        r_outValid <= 1'b0;
      end
    end
  end

`ifdef SHIFT_ISSUE_ZFLAG_EN
  logic r_outZ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outZ <= 1'b0;
    end else if (w_pop) begin
      r_outZ <= (sh_out == 16'h0000);
    end
  end

  assign out_z = r_outZ;
`else
  assign out_z = 1'b0;
`endif

  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_rd    = r_outRd;
  assign illegal   = r_illegal;

endmodule
